// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl: sequential shift-and-add multiplier, n x n -> 2n bits.
// Accepts start in IDLE, then spends up to n RUN cycles adding a shifted
// multiplicand into the accumulator. It pulses done for one cycle in DONE.
// Optional feature: define MUL_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero. The result is the same either way.
module shift_add_mul_ctrl #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] op_a,
    input  logic [n-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] product_lo,
    output logic [n-1:0] product_hi
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(n - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [2*n-1:0]  r_acc;
    logic [2*n-1:0]  r_mcand;
    logic [n-1:0]    r_mplier;
    logic [CW-1:0]   r_count;
    logic            r_busy;
    logic            r_done;

    logic [2*n-1:0]  w_sum;
    logic [2*n-1:0]  w_carry;

    // Explicit 2n-bit ripple-carry adder: acc + mcand. The carry out of the
    // top bit is never formed because the product always fits in 2n bits.
    assign w_carry[0] = 1'b0;
    for (genvar gi = 0; gi < 2*n; gi++) begin : g_rca
        assign w_sum[gi] = r_acc[gi] ^ r_mcand[gi] ^ w_carry[gi];
        if (gi < 2*n - 1) begin : g_carry
            assign w_carry[gi+1] = (r_acc[gi] & r_mcand[gi]) |
                                   (w_carry[gi] & (r_acc[gi] ^ r_mcand[gi]));
        end
    end

    // Control FSM plus the datapath registers. busy and done are registered
    // alongside the state, so they track RUN and DONE exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{n{1'b0}}, op_a};
                        r_mplier <= op_b;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
`ifdef MUL_EARLY_EXIT_EN
                    if (r_mplier == '0) begin
                        // All remaining partial products are zero, so stop now.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        if (r_mplier[0]) begin
                            r_acc <= w_sum;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + 1'b1;
                        if (r_count == LAST_COUNT) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign product_lo = r_acc[n-1:0];
    assign product_hi = r_acc[2*n-1:n];

endmodule
